// File: rtl/sample_seq_checker.sv
// Receive-side sequence checker: validates wrapping N-bit sample tags, extends
// them to a W-bit monotonic timestamp and counts dropped/duplicated samples.
module sample_seq_checker #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 32,
    parameter int unsigned D = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [N-1:0] IN_SEQ,
    input  logic [D-1:0] IN_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [D-1:0] OUT_DATA,
    output logic [W-1:0] OUT_TS,
    output logic         OUT_GAP,
    output logic         LOCKED,
    output logic [15:0]  DROP_COUNT,
    output logic [15:0]  DUP_COUNT,
    input  logic         CLR_STATS,
    input  logic         RESYNC
);

    typedef enum logic {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_t;

    localparam logic [N-1:0] SEQ_ONE = N'(1);
    localparam logic [W-1:0] TS_ONE  = W'(1);

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_out_valid;
    logic [D-1:0]   r_out_data;
    logic [W-1:0]   r_out_ts;
    logic           r_out_gap;
    logic [N-1:0]   r_last_seq;
    logic [15:0]    r_drop;
    logic [15:0]    r_dup;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_fresh;
    logic [N-1:0]   w_gap;
    logic           w_dup;
    logic           w_emit;
    logic           w_gap_flag;
    logic [W-1:0]   w_ts_nxt;
    logic [15:0]    w_drop_nxt;
    logic [15:0]    w_dup_nxt;

    assign w_in_ready = !r_out_valid || OUT_READY;
    assign w_accept   = IN_VALID && w_in_ready;
    // A sample arriving together with RESYNC starts the new lock.
    assign w_fresh    = (r_state == S_UNLOCKED) || RESYNC;
    assign w_gap      = IN_SEQ - r_last_seq - SEQ_ONE;
    assign w_dup      = !w_fresh && (IN_SEQ == r_last_seq);
    assign w_emit     = w_accept && !w_dup;
    assign w_gap_flag = !w_fresh && (w_gap != '0);
    assign w_ts_nxt   = w_fresh ? W'(IN_SEQ) : (r_out_ts + W'(w_gap) + TS_ONE);

    always_comb begin
        w_drop_nxt = r_drop;
        w_dup_nxt  = r_dup;
        if (CLR_STATS) begin
            w_drop_nxt = '0;
            w_dup_nxt  = '0;
        end else begin
            if (w_emit && w_gap_flag) begin
                w_drop_nxt = sat_add16(r_drop, 16'(w_gap));
            end
            if (w_accept && w_dup) begin
                w_dup_nxt = sat_add16(r_dup, 16'd1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_LOCKED;
        end else if (RESYNC) begin
            w_state_nxt = S_UNLOCKED;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output record register; the last emitted timestamp doubles as the running ts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ts    <= '0;
            r_out_gap   <= 1'b0;
            r_last_seq  <= '0;
            r_drop      <= '0;
            r_dup       <= '0;
        end else begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= IN_DATA;
                r_out_ts    <= w_ts_nxt;
                r_out_gap   <= w_gap_flag;
                r_last_seq  <= IN_SEQ;
            end else if (OUT_READY) begin
                r_out_valid <= 1'b0;
            end
            r_drop <= w_drop_nxt;
            r_dup  <= w_dup_nxt;
        end
    end

    assign IN_READY   = w_in_ready;
    assign OUT_VALID  = r_out_valid;
    assign OUT_DATA   = r_out_data;
    assign OUT_TS     = r_out_ts;
    assign OUT_GAP    = r_out_gap;
    assign LOCKED     = (r_state == S_LOCKED);
    assign DROP_COUNT = r_drop;
    assign DUP_COUNT  = r_dup;

endmodule

// File: tb/tb_sample_seq_checker.sv
// Scoreboard bench for sample_seq_checker: directed scenarios plus random traffic
// checked against a sequence/timestamp reference model.
module tb_sample_seq_checker;

    localparam int N = 8;
    localparam int W = 32;
    localparam int D = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [N-1:0] IN_SEQ = '0;
    logic [D-1:0] IN_DATA = '0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [D-1:0] OUT_DATA;
    logic [W-1:0] OUT_TS;
    logic         OUT_GAP;
    logic         LOCKED;
    logic [15:0]  DROP_COUNT;
    logic [15:0]  DUP_COUNT;
    logic         CLR_STATS = 1'b0;
    logic         RESYNC = 1'b0;

    always #5 CLK = ~CLK;

    sample_seq_checker #(.N(N), .W(W), .D(D)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SEQ(IN_SEQ), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_TS(OUT_TS), .OUT_GAP(OUT_GAP), .LOCKED(LOCKED),
        .DROP_COUNT(DROP_COUNT), .DUP_COUNT(DUP_COUNT),
        .CLR_STATS(CLR_STATS), .RESYNC(RESYNC)
    );

    typedef struct {
        logic [D-1:0] data;
        logic [W-1:0] ts;
        logic         gap;
    } rec_t;

    rec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state
    bit           m_locked = 0;
    int           m_last   = 0;
    logic [W-1:0] m_ts     = '0;
    int           m_drop   = 0;
    int           m_dup    = 0;
    bit           m_ovalid = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_clear();
        sb.delete();
        m_locked = 0;
        m_last   = 0;
        m_ts     = '0;
        m_drop   = 0;
        m_dup    = 0;
        m_ovalid = 0;
    endtask

    task automatic step(input bit v, input int seq, input bit ordy, input bit rs, input bit clr);
        bit   acc;
        bit   nv;
        int   gap;
        rec_t r;
        @(negedge CLK);
        chk("drop_count", DROP_COUNT, m_drop);
        chk("dup_count", DUP_COUNT, m_dup);
        chk("locked", LOCKED, m_locked);
        IN_VALID  = v;
        IN_SEQ    = N'(seq);
        IN_DATA   = D'($urandom);
        OUT_READY = ordy;
        RESYNC    = rs;
        CLR_STATS = clr;
        #1;
        chk("in_ready", IN_READY, (!m_ovalid || ordy));
        acc = v && IN_READY;
        if (rs) m_locked = 0;
        nv = ordy ? 1'b0 : m_ovalid;
        if (acc) begin
            seq = seq % 256;
            if (!m_locked) begin
                m_ts = W'(seq);
                r = '{data: IN_DATA, ts: m_ts, gap: 1'b0};
                sb.push_back(r);
                m_last = seq; m_locked = 1; nv = 1;
            end else if (seq == m_last) begin
                m_dup = (m_dup + 1 > 65535) ? 65535 : m_dup + 1;
            end else begin
                gap = (seq - (m_last + 1) + 512) % 256;
                m_ts = m_ts + W'(gap) + W'(1);
                r = '{data: IN_DATA, ts: m_ts, gap: (gap != 0)};
                sb.push_back(r);
                m_drop = (m_drop + gap > 65535) ? 65535 : m_drop + gap;
                m_last = seq; nv = 1;
            end
        end
        if (clr) begin
            m_drop = 0;
            m_dup  = 0;
        end
        m_ovalid = nv;
    endtask

    task automatic peek(input string name, input longint exp_ts, input bit exp_gap);
        @(posedge CLK); #1;
        chk({name, "_valid"}, OUT_VALID, 1);
        chk({name, "_ts"}, OUT_TS, exp_ts);
        chk({name, "_gap"}, OUT_GAP, exp_gap);
    endtask

    task automatic peek_cnt(input string name, input int exp_drop, input int exp_dup);
        @(posedge CLK); #1;
        chk({name, "_drop"}, DROP_COUNT, exp_drop);
        chk({name, "_dup"}, DUP_COUNT, exp_dup);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_in_ready"}, IN_READY, 1);
        chk({name, "_out_valid"}, OUT_VALID, 0);
        chk({name, "_out_gap"}, OUT_GAP, 0);
        chk({name, "_locked"}, LOCKED, 0);
        chk({name, "_out_ts"}, OUT_TS, 0);
        chk({name, "_out_data"}, OUT_DATA, 0);
        chk({name, "_drop"}, DROP_COUNT, 0);
        chk({name, "_dup"}, DUP_COUNT, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1; IN_VALID = 0; OUT_READY = 0; RESYNC = 0; CLR_STATS = 0;
        model_clear();
        @(negedge CLK);
        RST = 0;
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks hold stability.
    initial begin
        bit           hold = 0;
        logic [D-1:0] h_data;
        logic [W-1:0] h_ts;
        logic         h_gap;
        rec_t         e;
        forever begin
            @(negedge CLK); #2;
            if (RST) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", OUT_VALID, 1);
                chk("hold_ts", OUT_TS, h_ts);
                chk("hold_data", OUT_DATA, h_data);
                chk("hold_gap", OUT_GAP, h_gap);
                chk("hold_in_ready", IN_READY, OUT_READY);
            end
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_record", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rec_ts", OUT_TS, e.ts);
                    chk("rec_data", OUT_DATA, e.data);
                    chk("rec_gap", OUT_GAP, e.gap);
                end
                hold = 0;
            end else if (OUT_VALID) begin
                hold = 1; h_data = OUT_DATA; h_ts = OUT_TS; h_gap = OUT_GAP;
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        int k;
        repeat (2) @(negedge CLK);
        RST = 0;
        #1;
        check_reset_vals("reset");

        // Contiguous stream across the tag wrap
        step(1, 'hFD, 1, 0, 0);
        step(1, 'hFE, 1, 0, 0);
        step(1, 'hFF, 1, 0, 0);
        step(1, 'h00, 1, 0, 0);
        step(1, 'h01, 1, 0, 0);
        peek("wrap", 'h101, 0);
        chk("wrap_drop", DROP_COUNT, 0);

        // Gap across the wrap
        step(1, 'hFE, 1, 1, 1);
        step(1, 'h02, 1, 0, 0);
        peek("gapwrap", 'h102, 1);
        chk("gapwrap_drop", DROP_COUNT, 3);

        // Duplicate discard
        step(1, 5, 1, 1, 1);
        step(1, 5, 1, 0, 0);
        step(1, 6, 1, 0, 0);
        peek("dup", 6, 0);
        chk("dup_dupcount", DUP_COUNT, 1);
        chk("dup_drop", DROP_COUNT, 0);

        // Backpressure with IN_VALID held high
        repeat (4) step(1, 7, 0, 0, 0);
        step(1, 7, 1, 0, 0);
        step(1, 8, 1, 0, 0);

        // RESYNC while locked at ts 0x105
        step(1, 'hFF, 1, 1, 0);
        step(1, 'h05, 1, 0, 0);
        peek("ts105", 'h105, 1);
        step(0, 0, 1, 1, 0);
        step(1, 'h40, 1, 0, 0);
        peek("resync", 'h40, 0);

        // Reset while a record is pending
        step(1, 'h41, 1, 0, 0);
        do_reset();
        check_reset_vals("midreset");

        // DROP_COUNT saturation, then clear colliding with a gap of 4
        step(1, 0, 1, 1, 0);
        s = 0;
        repeat (260) begin
            s = (s + 255) % 256;
            step(1, s, 1, 0, 0);
        end
        peek_cnt("sat", 'hFFFF, 0);
        step(1, (s + 5) % 256, 1, 0, 1);
        peek_cnt("clr", 0, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      s = m_last;
            else if (k <= 6) s = (m_last + 1) % 256;
            else             s = (m_last + 1 + $urandom_range(1, 20)) % 256;
            step($urandom_range(0, 3) != 0, s, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
        end

        repeat (3) step(0, 0, 1, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
